// File: rtl/snes_pad_pkg.sv
// Shared definitions for the SNES pad protocol blocks (host poller and
// device-side responder): state encoding, button bit positions, frame sizes.
package snes_pad_pkg;

  localparam int SNES_NUM_BUTTONS = 12;
  localparam int SNES_FRAME_BITS  = 16;

  // Button positions inside the 12-bit button vector / serial frame
  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOADED   = 2'd1,
    ST_SHIFTING = 2'd2,
    ST_DONE     = 2'd3
  } snes_state_e;

  // A frame is in progress while the latch is held or bits are being shifted
  function automatic logic snes_is_active(input snes_state_e s);
    return (s == ST_LOADED) || (s == ST_SHIFTING);
  endfunction

endpackage

// File: rtl/snes_sync_edge.sv
// Brings an asynchronous pin into the clock domain through a STAGES-deep
// flop chain, then one more flop to detect the rising edge of the
// synchronized level.
module snes_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  // Next values: shift the pin into the chain, remember last synced level
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
  end

  // Synchronizer and edge-detect flops, cleared to 0 on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/snes_pad_responder.sv
// Device side of the SNES serial pad link: captures BUTTONS while the host
// holds LATCH (4021-style parallel load) and shifts one bit per PULSE rising
// edge onto DATA, active-low.
// Optional macro SNES_PAD_RESPONDER_TIMEOUT_EN adds an idle counter that
// abandons a SHIFTING frame after TIMEOUT_CYCLES without a pulse edge.
module snes_pad_responder
  import snes_pad_pkg::*;
#(
  parameter int   SYNC_STAGES    = 2,
  parameter int   NUM_BITS       = SNES_FRAME_BITS,
  parameter logic FILL_BIT       = 1'b0,
  parameter int   TIMEOUT_CYCLES = 50000
) (
  input  logic                        CLOCK,
  input  logic                        RESET,
  input  logic                        LATCH,
  input  logic                        PULSE,
  output logic                        DATA,
  input  logic [SNES_NUM_BUTTONS-1:0] BUTTONS,
  output logic [4:0]                  BIT_INDEX,
  output logic                        ACTIVE,
  output logic                        FRAME_DONE
);

  if (SYNC_STAGES < 2 || NUM_BITS < SNES_NUM_BUTTONS || NUM_BITS > 31 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
    $error("snes_pad_responder: parameter out of range");
  end

  localparam logic [4:0] LAST_IDX = 5'(NUM_BITS - 1);

  logic lat_s, lat_rise, pul_rise, pul_s_unused;

  snes_sync_edge #(.STAGES(SYNC_STAGES)) u_lat_sync (
    .clk   (CLOCK),
    .rst   (RESET),
    .din   (LATCH),
    .level (lat_s),
    .rise  (lat_rise)
  );

  snes_sync_edge #(.STAGES(SYNC_STAGES)) u_pul_sync (
    .clk   (CLOCK),
    .rst   (RESET),
    .din   (PULSE),
    .level (pul_s_unused),
    .rise  (pul_rise)
  );

  // Parallel-load word: inverted buttons in the low bits, idle-high padding above
  logic [NUM_BITS-1:0] load_word;
  for (genvar i = 0; i < NUM_BITS; i++) begin : g_load
    if (i < SNES_NUM_BUTTONS) begin : g_btn
      assign load_word[i] = ~BUTTONS[i];
    end else begin : g_pad
      assign load_word[i] = 1'b1;
    end
  end

  snes_state_e         state_q, state_d;
  logic [NUM_BITS-1:0] shreg_q, shreg_d;
  logic [4:0]          idx_q, idx_d;
  logic                done_q, done_d;

`ifdef SNES_PAD_RESPONDER_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] idle_q, idle_d;

  // Idle counter only runs while waiting for the next pulse edge
  always_comb begin
    idle_d = '0;
    if (state_q == ST_SHIFTING && !lat_rise && !pul_rise)
      idle_d = idle_q + 16'd1;
  end
`endif

  // Frame sequencing; a latch edge wins over everything, including a pulse
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    if (lat_rise) begin
      state_d = ST_LOADED;
      shreg_d = load_word;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_LOADED: begin
          // Track the buttons live until the latch drops, then freeze
          if (lat_s) shreg_d = load_word;
          else       state_d = ST_SHIFTING;
        end
        ST_SHIFTING: begin
          if (pul_rise && !lat_s) begin
            shreg_d = {FILL_BIT, shreg_q[NUM_BITS-1:1]};
            idx_d   = idx_q + 5'd1;
            if (idx_q == LAST_IDX) begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end
          end
`ifdef SNES_PAD_RESPONDER_TIMEOUT_EN
          else if (idle_q == TO_LAST) begin
            // Host went away mid-frame: drop back to the idle-high line
            state_d = ST_IDLE;
            shreg_d = '1;
            idx_d   = '0;
          end
`endif
        end
        default: ;  // IDLE and DONE only leave on a latch edge
      endcase
    end
  end

  // State and registered outputs; reset clears asynchronously
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      shreg_q <= '1;
      idx_q   <= '0;
      done_q  <= 1'b0;
`ifdef SNES_PAD_RESPONDER_TIMEOUT_EN
      idle_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
`ifdef SNES_PAD_RESPONDER_TIMEOUT_EN
      idle_q  <= idle_d;
`endif
    end
  end

  assign DATA       = shreg_q[0];
  assign BIT_INDEX  = idx_q;
  assign ACTIVE     = snes_is_active(state_q);
  assign FRAME_DONE = done_q;

endmodule
